// File: rtl/pll_lock_supervisor.sv
// Bring-up/recovery sequencer for the DVI pixel-clock PLL, clocked by the free-running reference.
// It debounces lock, releases the video reset after a guard interval and retries a bounded number of times before raising fault.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 32,
  parameter int LOCK_TIMEOUT   = 27000,
  parameter int LOCK_FILTER    = 256,
  parameter int RST_HOLD       = 64,
  parameter int MAX_RETRIES    = 4
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       dvi_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int M1      = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2      = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] FLT_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST_PLL, S_WAIT_LOCK, S_FILTER, S_HOLD, S_RUN, S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d, retry_inc;
  logic [7:0]    lost_q, lost_d;
  logic          sync1_q, lock_s_q;
  logic          pll_reset_q, dvi_reset_q, ready_q, fault_q;
  logic          lock_lost;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_d   = retry_q;
    lost_d    = lost_q;
    retry_inc = retry_q + 4'd1;
    lock_lost = ((state_q == S_HOLD) || (state_q == S_RUN)) && !lock_s_q;

    // A loss counts even when relock_req wins the transition in the same cycle.
    if (lock_lost && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;

    if (relock_req && (state_q != S_RST_PLL)) begin
      state_d = S_RST_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RST_PLL:   if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s_q) state_d = S_FILTER;
          else if (cnt_q == TMO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIM) ? S_FAULT : S_RST_PLL;
          end
        end
        S_FILTER: begin
          if (!lock_s_q)              state_d = S_WAIT_LOCK;
          else if (cnt_q == FLT_LAST) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (!lock_s_q) state_d = S_RST_PLL;
          else if (cnt_q == HOLD_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN:   if (!lock_s_q) state_d = S_RST_PLL;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RST_PLL;
      endcase
    end

    // Every state change restarts the shared dwell counter.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      pll_reset_q <= 1'b1;
      dvi_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset_q <= (state_d == S_RST_PLL);
      dvi_reset_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign pll_reset = pll_reset_q;
  assign dvi_reset = dvi_reset_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus queues expected output snapshots tagged with an edge number, and the monitor checks them on the falling edge.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset, pll_lock, relock_req;
  logic       pll_reset, dvi_reset, ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_FILTER(8), .RST_HOLD(6), .MAX_RETRIES(3)
  ) dut (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_reset(pll_reset), .dvi_reset(dvi_reset), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [15:0] obs = {pll_reset, dvi_reset, ready, fault, retry_cnt, lost_cnt};

  // Monitor: every queued snapshot due at this edge is compared and retired.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (obs !== sb[i].exp) begin
          errors++;
          $display("FAIL %s @edge %0d: got %h want %h (pr,dr,rdy,flt,retry,lost)",
                   sb[i].name, cyc, obs, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  function automatic logic [15:0] vec(input logic pr, input logic dr, input logic rd,
                                      input logic f, input int rt, input int lo);
    return {pr, dr, rd, f, 4'(rt), 8'(lo)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input string nm, input logic [15:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Holds reset over two edges; the last reset edge is the base for the caller's offsets.
  task automatic start(input logic lk);
    reset      = 1'b1;
    pll_lock   = lk;
    relock_req = 1'b0;
    tick(2);
    expect_at(cyc, "reset_vals", vec(1, 1, 0, 0, 0, 0));
    reset = 1'b0;
  endtask

  initial begin
    int b, d;
    reset = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
    tick(1);

    // Clean bring-up: lock rises 3 cycles after pll_reset falls.
    start(1'b0); b = cyc;
    expect_at(b + 3,  "s1_prst_hi",  vec(1, 1, 0, 0, 0, 0));
    expect_at(b + 4,  "s1_prst_lo",  vec(0, 1, 0, 0, 0, 0));
    expect_at(b + 23, "s1_pre_run",  vec(0, 1, 0, 0, 0, 0));
    expect_at(b + 24, "s1_run",      vec(0, 0, 1, 0, 0, 0));
    tick(7); pll_lock = 1'b1;
    tick(20);

    // Single-cycle lock drop in RUN, then full re-bring-up.
    d = cyc;
    pll_lock = 1'b0;
    expect_at(d + 2,  "s4_pre_loss", vec(0, 0, 1, 0, 0, 0));
    expect_at(d + 3,  "s4_loss",     vec(1, 1, 0, 0, 0, 1));
    expect_at(d + 6,  "s4_prst_hi",  vec(1, 1, 0, 0, 0, 1));
    expect_at(d + 7,  "s4_prst_lo",  vec(0, 1, 0, 0, 0, 1));
    expect_at(d + 21, "s4_pre_run",  vec(0, 1, 0, 0, 0, 1));
    expect_at(d + 22, "s4_rerun",    vec(0, 0, 1, 0, 0, 1));
    tick(1); pll_lock = 1'b1;
    tick(24);

    // Second loss, then reset asserted mid-HOLD clears everything including lost_cnt.
    d = cyc;
    pll_lock = 1'b0;
    tick(1); pll_lock = 1'b1;
    tick(17);
    expect_at(d + 18, "s6_in_hold",  vec(0, 1, 0, 0, 0, 2));
    reset = 1'b1;
    tick(1);
    expect_at(d + 19, "s6_hold_rst", vec(1, 1, 0, 0, 0, 0));

    // Glitchy lock: high 5, low 2, then high.
    start(1'b0); b = cyc;
    expect_at(b + 14, "s2_filter",   vec(0, 1, 0, 0, 0, 0));
    expect_at(b + 24, "s2_no_early", vec(0, 1, 0, 0, 0, 0));
    expect_at(b + 30, "s2_pre_run",  vec(0, 1, 0, 0, 0, 0));
    expect_at(b + 31, "s2_run",      vec(0, 0, 1, 0, 0, 0));
    tick(7); pll_lock = 1'b1;
    tick(5); pll_lock = 1'b0;
    tick(2); pll_lock = 1'b1;
    tick(21);

    // Lock never arrives: three 4-cycle pll_reset pulses, then FAULT.
    start(1'b0); b = cyc;
    expect_at(b + 23, "s3_wait1",    vec(0, 1, 0, 0, 0, 0));
    expect_at(b + 24, "s3_retry1",   vec(1, 1, 0, 0, 1, 0));
    expect_at(b + 27, "s3_pulse2",   vec(1, 1, 0, 0, 1, 0));
    expect_at(b + 28, "s3_wait2",    vec(0, 1, 0, 0, 1, 0));
    expect_at(b + 47, "s3_wait2end", vec(0, 1, 0, 0, 1, 0));
    expect_at(b + 48, "s3_retry2",   vec(1, 1, 0, 0, 2, 0));
    expect_at(b + 51, "s3_pulse3",   vec(1, 1, 0, 0, 2, 0));
    expect_at(b + 52, "s3_wait3",    vec(0, 1, 0, 0, 2, 0));
    expect_at(b + 71, "s3_pre_flt",  vec(0, 1, 0, 0, 2, 0));
    expect_at(b + 72, "s3_fault",    vec(0, 1, 0, 1, 3, 0));
    expect_at(b + 80, "s3_fault_st", vec(0, 1, 0, 1, 3, 0));
    tick(80);

    // relock_req out of FAULT; a second request during RST_PLL must not extend it.
    relock_req = 1'b1;
    expect_at(b + 81, "s5_relock",   vec(1, 1, 0, 0, 0, 0));
    expect_at(b + 84, "s5_pulse",    vec(1, 1, 0, 0, 0, 0));
    expect_at(b + 85, "s5_ignored",  vec(0, 1, 0, 0, 0, 0));
    tick(1); relock_req = 1'b0;
    tick(1); relock_req = 1'b1;
    tick(1); relock_req = 1'b0;
    tick(5);

    // Lock high through reset: ready at 4+1+8+6 edges, then 260 losses saturate lost_cnt.
    start(1'b1); b = cyc;
    expect_at(b + 18, "s7_pre_run",  vec(0, 1, 0, 0, 0, 0));
    expect_at(b + 19, "s7_run",      vec(0, 0, 1, 0, 0, 0));
    tick(25);
    for (int k = 1; k <= 260; k++) begin
      d = cyc;
      pll_lock = 1'b0;
      expect_at(d + 3, $sformatf("lost_inc_%0d", k), vec(1, 1, 0, 0, 0, (k > 255) ? 255 : k));
      tick(1); pll_lock = 1'b1;
      tick(24);
    end
    expect_at(cyc, "s7_sat_run", vec(0, 0, 1, 0, 0, 255));
    tick(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
